// File: rtl/pkt_match_pkg.sv
// Shared types and constants for the packet match responder.
// Holds the result/entry record layouts, receive FSM states and the
// broadcast address used by the lookup.
package pkt_match_pkg;

    localparam int TAG_W  = 10;
    localparam int MASK_W = 4;
    localparam int MAC_W  = 48;

    localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [MASK_W-1:0] mask;
        logic [TAG_W-1:0]  tag;
    } match_result_t;

    typedef struct packed {
        logic              en;
        logic [MAC_W-1:0]  mac;
        logic [MASK_W-1:0] mask;
    } match_entry_t;

    typedef enum logic {
        IDLE,
        BODY
    } rx_state_t;

    localparam int RES_W = $bits(match_result_t);

    // A broadcast destination always falls back to the default port mask.
    function automatic logic isBroadcast(input logic [MAC_W-1:0] mac);
        return (mac == BCAST_MAC);
    endfunction

endpackage

// File: rtl/pkt_match_fifo.sv
// Show-ahead synchronous FIFO of match results.
// The head entry is presented combinationally whenever the FIFO is not
// empty; the output reads as zero while empty so nothing stale leaks out.
// A push is accepted when full provided a pop happens in the same cycle.
module pkt_match_fifo
    import pkt_match_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [RES_W-1:0]             i_data,
    input  logic                         i_pop,
    output logic [RES_W-1:0]             o_data,
    output logic                         o_valid,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

    match_result_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_doPop;
    logic w_doPush;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == LP_DEPTH);
    assign w_doPop  = i_pop && !w_empty;
    assign w_doPush = i_push && (!w_full || w_doPop);

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + 1'b1;
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/pkt_match_responder.sv
// Packet match responder: captures tag and destination MAC from the first
// beat of each packet, looks the MAC up in a small programmable table one
// cycle later, and queues {port_mask, tag} until the consumer takes it.
// Optional feature macro: PKT_MATCH_STATS_EN adds stat_hits/stat_misses.
module pkt_match_responder
    import pkt_match_pkg::*;
#(
    parameter int                NUM_ENTRIES  = 8,
    parameter int                FIFO_DEPTH   = 4,
    parameter logic [MASK_W-1:0] DEFAULT_MASK = 4'hF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [73:0]                    packet_data,
    input  logic                           packet_valid,
    input  logic                           packet_sop,
    input  logic                           packet_eop,
    output logic                           packet_ready,
    output logic [13:0]                    tagout_data,
    output logic                           tagout_valid,
    input  logic                           tagout_ready,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx,
    input  logic                           cfg_en,
    input  logic [47:0]                    cfg_mac,
    input  logic [3:0]                     cfg_mask,
`ifdef PKT_MATCH_STATS_EN
    output logic [31:0]                    stat_hits,
    output logic [31:0]                    stat_misses,
`endif
    output logic [15:0]                    err_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(FIFO_DEPTH);

    rx_state_t r_state;
    rx_state_t w_nextState;

    logic             w_readyRule;
    logic             w_accept;
    logic             w_capture;
    logic             w_protoErr;
    logic [CNT_W-1:0] w_fifoCount;
    logic [CNT_W-1:0] w_occupancy;

    logic             r_pending;
    logic [TAG_W-1:0] r_tag;
    logic [MAC_W-1:0] r_dmac;

    match_entry_t      r_table [NUM_ENTRIES];
    logic              w_hit;
    logic [MASK_W-1:0] w_hitMask;
    logic              w_bcast;
    match_result_t     w_result;

    logic [15:0] r_errCount;
    logic        w_unusedPayload;

    // The low payload bytes never influence the lookup.
    assign w_unusedPayload = ^packet_data[15:0];

    // Pending lookups count against FIFO space so every header has a slot.
    assign w_occupancy  = w_fifoCount + {{(CNT_W-1){1'b0}}, r_pending};
    assign w_readyRule  = (r_state == BODY) || (w_occupancy < LP_DEPTH);
    assign packet_ready = reset && w_readyRule;
    assign w_accept     = packet_valid && packet_ready;

    // Receive state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Packet framing: decide header capture, protocol errors and next state.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_protoErr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (packet_sop) begin
                        w_capture = 1'b1;
                        if (!packet_eop) begin
                            w_nextState = BODY;
                        end
                    end else begin
                        w_protoErr = 1'b1;
                    end
                end
            end
            BODY: begin
                if (w_accept) begin
                    if (packet_sop) begin
                        w_capture  = 1'b1;
                        w_protoErr = 1'b1;
                    end
                    if (packet_eop) begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Latch the header fields; the lookup runs the cycle after capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
            r_tag     <= '0;
            r_dmac    <= '0;
        end else begin
            r_pending <= w_capture;
            if (w_capture) begin
                r_tag  <= packet_data[73:64];
                r_dmac <= packet_data[63:16];
            end
        end
    end

    // Table writes land at the clock edge, so a same-cycle lookup sees old data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we) begin
            r_table[cfg_idx] <= '{en: cfg_en, mac: cfg_mac, mask: cfg_mask};
        end
    end

    // Scan high to low so the lowest matching index is the one that sticks.
    always_comb begin
        w_hit     = 1'b0;
        w_hitMask = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (r_table[i].en && (r_table[i].mac == r_dmac)) begin
                w_hit     = 1'b1;
                w_hitMask = r_table[i].mask;
            end
        end
    end

    assign w_bcast       = isBroadcast(r_dmac);
    assign w_result.mask = (w_bcast || !w_hit) ? DEFAULT_MASK : w_hitMask;
    assign w_result.tag  = r_tag;

    // Saturating count of framing violations.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_errCount <= '0;
        end else if (w_protoErr && (r_errCount != 16'hFFFF)) begin
            r_errCount <= r_errCount + 16'd1;
        end
    end

    assign err_count = r_errCount;

`ifdef PKT_MATCH_STATS_EN
    logic [31:0] r_statHits;
    logic [31:0] r_statMisses;

    // Wrapping hit/miss counters, updated in the lookup cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_statHits   <= '0;
            r_statMisses <= '0;
        end else if (r_pending) begin
            if (w_hit && !w_bcast) begin
                r_statHits <= r_statHits + 32'd1;
            end else begin
                r_statMisses <= r_statMisses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_statHits;
    assign stat_misses = r_statMisses;
`endif

    pkt_match_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (r_pending),
        .i_data  (w_result),
        .i_pop   (tagout_ready),
        .o_data  (tagout_data),
        .o_valid (tagout_valid),
        .o_count (w_fifoCount)
    );

endmodule

// File: tb/tb_pkt_match_responder.sv
// Testbench for pkt_match_responder: directed scenarios plus a randomized
// run scored against a table-lookup reference model.
module tb_pkt_match_responder;
    import pkt_match_pkg::*;

    localparam int NE = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [73:0] packet_data = '0;
    logic        packet_valid = 1'b0;
    logic        packet_sop = 1'b0;
    logic        packet_eop = 1'b0;
    logic        packet_ready;
    logic [13:0] tagout_data;
    logic        tagout_valid;
    logic        tagout_ready = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic        cfg_en = 1'b0;
    logic [47:0] cfg_mac = '0;
    logic [3:0]  cfg_mask = '0;
    logic [15:0] err_count;
`ifdef PKT_MATCH_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int nChecks = 0;
    int nPass   = 0;

    bit          mEn   [NE];
    logic [47:0] mMac  [NE];
    logic [3:0]  mMask [NE];
    logic [13:0] expQ [$];

    localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_P = 48'hAABB_CCDD_EE01;

    always #5 clock = ~clock;

    pkt_match_responder #(
        .NUM_ENTRIES (8),
        .FIFO_DEPTH  (4),
        .DEFAULT_MASK(4'hF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .packet_data (packet_data),
        .packet_valid(packet_valid),
        .packet_sop  (packet_sop),
        .packet_eop  (packet_eop),
        .packet_ready(packet_ready),
        .tagout_data (tagout_data),
        .tagout_valid(tagout_valid),
        .tagout_ready(tagout_ready),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_mac     (cfg_mac),
        .cfg_mask    (cfg_mask),
`ifdef PKT_MATCH_STATS_EN
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
`endif
        .err_count   (err_count)
    );

    // Reference: broadcast or no enabled match -> default; else first match in index order.
    function automatic logic [3:0] refMask(input logic [47:0] dmac);
        if (dmac == 48'hFFFF_FFFF_FFFF) return 4'hF;
        for (int i = 0; i < NE; i++) begin
            if (mEn[i] && mMac[i] == dmac) return mMask[i];
        end
        return 4'hF;
    endfunction

    function automatic logic [73:0] mkHdr(input logic [9:0] tag, input logic [47:0] dmac);
        return {tag, dmac, 16'($urandom)};
    endfunction

    function automatic logic [73:0] mkBody();
        return {10'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < NE; i++) begin
            mEn[i] = 1'b0; mMac[i] = '0; mMask[i] = '0;
        end
        expQ.delete();
    endtask

    task automatic cfgWrite(input int idx, input bit en, input logic [47:0] mac, input logic [3:0] mask);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_en = en; cfg_mac = mac; cfg_mask = mask;
        tick();
        cfg_we = 1'b0;
        mEn[idx] = en; mMac[idx] = mac; mMask[idx] = mask;
    endtask

    // Present one beat and hold it until accepted (bounded); returns just after the accepting edge.
    task automatic sendBeat(input logic [73:0] data, input logic sop, input logic eop, output logic ok);
        int n;
        packet_data = data; packet_sop = sop; packet_eop = eop; packet_valid = 1'b1;
        n = 0;
        while (!packet_ready && n < 200) begin
            tick();
            n++;
        end
        ok = packet_ready;
        if (ok) tick();
        packet_valid = 1'b0; packet_sop = 1'b0; packet_eop = 1'b0;
    endtask

    task automatic popOne();
        tagout_ready = 1'b1;
        tick();
        tagout_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clearModel();
        repeat (3) tick();
        nChecks++; if (packet_ready !== 1'b0) $display("[TB] FAIL rst_ready got %b expected 0", packet_ready); else nPass++;
        nChecks++; if (tagout_valid !== 1'b0) $display("[TB] FAIL rst_valid got %b expected 0", tagout_valid); else nPass++;
        nChecks++; if (tagout_data !== 14'h0) $display("[TB] FAIL rst_data got %h expected 0", tagout_data); else nPass++;
        nChecks++; if (err_count !== 16'h0) $display("[TB] FAIL rst_err got %0d expected 0", err_count); else nPass++;
        reset = 1'b1;
        #1;
        nChecks++; if (packet_ready !== 1'b1) $display("[TB] FAIL rst_release_ready got %b expected 1", packet_ready); else nPass++;
        tick();
    endtask

    task automatic test_exact_hit();
        logic ok0, ok1, ok2;
        cfgWrite(2, 1'b1, MAC_A, 4'b0100);
        sendBeat(mkHdr(10'h05A, MAC_A), 1'b1, 1'b0, ok0);
        nChecks++; if (!ok0 || tagout_valid !== 1'b0) $display("[TB] FAIL hit_t1 got valid=%b ok=%b expected valid=0 ok=1", tagout_valid, ok0); else nPass++;
        sendBeat(mkBody(), 1'b0, 1'b0, ok1);
        nChecks++; if (!ok1 || tagout_valid !== 1'b1 || tagout_data !== 14'h105A)
            $display("[TB] FAIL hit_t2 got valid=%b data=%h expected valid=1 data=105a", tagout_valid, tagout_data); else nPass++;
        sendBeat(mkBody(), 1'b0, 1'b1, ok2);
        popOne();
        nChecks++; if (!ok2 || tagout_valid !== 1'b0) $display("[TB] FAIL hit_drain got valid=%b expected 0", tagout_valid); else nPass++;
    endtask

    task automatic test_miss_bcast();
        logic ok;
        cfgWrite(3, 1'b1, 48'hFFFF_FFFF_FFFF, 4'b0010);
        sendBeat(mkHdr(10'h123, 48'hDEAD_BEEF_0001), 1'b1, 1'b1, ok);
        tick();
        nChecks++; if (!ok || tagout_valid !== 1'b1 || tagout_data !== {4'hF, 10'h123})
            $display("[TB] FAIL miss got valid=%b data=%h expected %h", tagout_valid, tagout_data, {4'hF, 10'h123}); else nPass++;
        popOne();
        sendBeat(mkHdr(10'h2F0, 48'hFFFF_FFFF_FFFF), 1'b1, 1'b1, ok);
        tick();
        nChecks++; if (!ok || tagout_valid !== 1'b1 || tagout_data !== {4'hF, 10'h2F0})
            $display("[TB] FAIL bcast got valid=%b data=%h expected %h", tagout_valid, tagout_data, {4'hF, 10'h2F0}); else nPass++;
        popOne();
    endtask

    task automatic test_priority();
        logic ok;
        cfgWrite(1, 1'b1, MAC_P, 4'b0001);
        cfgWrite(5, 1'b1, MAC_P, 4'b1000);
        sendBeat(mkHdr(10'h2AA, MAC_P), 1'b1, 1'b1, ok);
        tick();
        nChecks++; if (!ok || tagout_data !== {4'b0001, 10'h2AA})
            $display("[TB] FAIL prio_low got %h expected %h", tagout_data, {4'b0001, 10'h2AA}); else nPass++;
        popOne();
        // rewrite entry 1 during the lookup cycle: this packet must still see the old mask
        sendBeat(mkHdr(10'h2AB, MAC_P), 1'b1, 1'b1, ok);
        cfg_we = 1'b1; cfg_idx = 3'd1; cfg_en = 1'b1; cfg_mac = MAC_P; cfg_mask = 4'b0110;
        tick();
        cfg_we = 1'b0;
        nChecks++; if (!ok || tagout_data !== {4'b0001, 10'h2AB})
            $display("[TB] FAIL prio_old_table got %h expected %h", tagout_data, {4'b0001, 10'h2AB}); else nPass++;
        mMask[1] = 4'b0110;
        popOne();
        sendBeat(mkHdr(10'h2AC, MAC_P), 1'b1, 1'b1, ok);
        tick();
        nChecks++; if (!ok || tagout_data !== {refMask(MAC_P), 10'h2AC})
            $display("[TB] FAIL prio_new_table got %h expected %h", tagout_data, {refMask(MAC_P), 10'h2AC}); else nPass++;
        popOne();
        cfgWrite(1, 1'b0, MAC_P, 4'b0110);
        sendBeat(mkHdr(10'h2AD, MAC_P), 1'b1, 1'b1, ok);
        tick();
        nChecks++; if (!ok || tagout_data !== {4'b1000, 10'h2AD})
            $display("[TB] FAIL prio_disabled got %h expected %h", tagout_data, {4'b1000, 10'h2AD}); else nPass++;
        popOne();
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [47:0] macs [6];
        int accepted = 0;
        macs = '{MAC_A, MAC_P, 48'h1, 48'hFFFF_FFFF_FFFF, MAC_A, 48'h77};
        tagout_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sendBeat(mkHdr(10'(10'h100 + k), macs[k]), 1'b1, 1'b1, ok);
            if (ok) begin
                accepted++;
                expQ.push_back({refMask(macs[k]), 10'(10'h100 + k)});
            end
        end
        nChecks++; if (accepted != 4 || packet_ready !== 1'b0)
            $display("[TB] FAIL bp_full got accepted=%0d ready=%b expected 4 and 0", accepted, packet_ready); else nPass++;
        packet_data = mkHdr(10'h104, macs[4]); packet_sop = 1'b1; packet_eop = 1'b1; packet_valid = 1'b1;
        repeat (3) tick();
        nChecks++; if (packet_ready !== 1'b0 || tagout_valid !== 1'b1 || tagout_data !== expQ[0])
            $display("[TB] FAIL bp_hold got ready=%b data=%h expected ready=0 data=%h", packet_ready, tagout_data, expQ[0]); else nPass++;
        fork
            begin
                for (int k = 4; k < 6; k++) begin
                    sendBeat(mkHdr(10'(10'h100 + k), macs[k]), 1'b1, 1'b1, ok);
                    if (ok) begin
                        accepted++;
                        expQ.push_back({refMask(macs[k]), 10'(10'h100 + k)});
                    end
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                tagout_ready = 1'b1;
                while (got < 6 && cyc < 100) begin
                    if (tagout_valid) begin
                        logic [13:0] e;
                        e = (expQ.size() > 0) ? expQ.pop_front() : 14'h0;
                        nChecks++; if (tagout_data !== e)
                            $display("[TB] FAIL bp_order[%0d] got %h expected %h", got, tagout_data, e); else nPass++;
                        got++;
                    end
                    tick();
                    cyc++;
                end
                tagout_ready = 1'b0;
                nChecks++; if (got != 6) $display("[TB] FAIL bp_drain_count got %0d expected 6", got); else nPass++;
            end
        join
        nChecks++; if (accepted != 6) $display("[TB] FAIL bp_accept got %0d expected 6", accepted); else nPass++;
    endtask

    task automatic test_errors();
        logic ok;
        logic [13:0] eA, eB;
        tagout_ready = 1'b0;
        eA = {refMask(MAC_A), 10'h0A1};
        eB = {refMask(48'h5), 10'h0B2};
        sendBeat(mkHdr(10'h0A1, MAC_A), 1'b1, 1'b0, ok);
        sendBeat(mkBody(), 1'b0, 1'b0, ok);
        sendBeat(mkHdr(10'h0B2, 48'h5), 1'b1, 1'b0, ok);
        sendBeat(mkBody(), 1'b0, 1'b1, ok);
        sendBeat(mkBody(), 1'b0, 1'b0, ok);
        repeat (2) tick();
        nChecks++; if (err_count !== 16'd2) $display("[TB] FAIL err_count got %0d expected 2", err_count); else nPass++;
        nChecks++; if (tagout_valid !== 1'b1 || tagout_data !== eA) $display("[TB] FAIL err_resA got %h expected %h", tagout_data, eA); else nPass++;
        popOne();
        nChecks++; if (tagout_valid !== 1'b1 || tagout_data !== eB) $display("[TB] FAIL err_resB got %h expected %h", tagout_data, eB); else nPass++;
        popOne();
        nChecks++; if (tagout_valid !== 1'b0) $display("[TB] FAIL err_dropped got valid=%b expected 0", tagout_valid); else nPass++;
    endtask

    task automatic test_reset_mid();
        logic ok;
        tagout_ready = 1'b0;
        sendBeat(mkHdr(10'h011, MAC_A), 1'b1, 1'b1, ok);
        sendBeat(mkHdr(10'h022, MAC_P), 1'b1, 1'b1, ok);
        sendBeat(mkHdr(10'h033, MAC_A), 1'b1, 1'b0, ok);
        sendBeat(mkBody(), 1'b0, 1'b0, ok);
        reset = 1'b0;
        #1;
        nChecks++; if (packet_ready !== 1'b0 || tagout_valid !== 1'b0 || tagout_data !== 14'h0 || err_count !== 16'h0)
            $display("[TB] FAIL midrst_outputs got ready=%b valid=%b data=%h err=%0d expected all 0",
                     packet_ready, tagout_valid, tagout_data, err_count); else nPass++;
        tick();
        reset = 1'b1;
        clearModel();
        tick();
        nChecks++; if (tagout_valid !== 1'b0 || packet_ready !== 1'b1)
            $display("[TB] FAIL midrst_empty got valid=%b ready=%b expected 0 and 1", tagout_valid, packet_ready); else nPass++;
        sendBeat(mkBody(), 1'b0, 1'b1, ok);
        tick();
        nChecks++; if (err_count !== 16'd1 || tagout_valid !== 1'b0)
            $display("[TB] FAIL midrst_nonsop got err=%0d valid=%b expected 1 and 0", err_count, tagout_valid); else nPass++;
        sendBeat(mkHdr(10'h077, MAC_A), 1'b1, 1'b1, ok);
        nChecks++; if (!ok || tagout_valid !== 1'b0) $display("[TB] FAIL midrst_t1 got valid=%b expected 0", tagout_valid); else nPass++;
        tick();
        nChecks++; if (tagout_valid !== 1'b1 || tagout_data !== {4'hF, 10'h077})
            $display("[TB] FAIL midrst_pkt got %h expected %h", tagout_data, {4'hF, 10'h077}); else nPass++;
        popOne();
    endtask

    task automatic test_random();
        logic [47:0] pool [4];
        localparam int NPKT = 60;
        int got = 0;
        bit timedOut = 1'b0;
        pool = '{48'h0000_1111_2222, 48'h0000_3333_4444, MAC_A, MAC_P};
        for (int i = 0; i < NE; i++) begin
            cfgWrite(i, ($urandom % 4) != 0, pool[$urandom % 4], 4'($urandom));
        end
        fork
            begin
                for (int p = 0; p < NPKT; p++) begin
                    logic ok;
                    logic [9:0] tag;
                    logic [47:0] dmac;
                    int len;
                    int sel;
                    tag = 10'($urandom);
                    sel = $urandom % 6;
                    dmac = (sel < 4) ? pool[sel] : (sel == 4) ? 48'hFFFF_FFFF_FFFF : {16'h0, 32'($urandom)};
                    len = 1 + ($urandom % 3);
                    sendBeat(mkHdr(tag, dmac), 1'b1, len == 1, ok);
                    if (!ok) timedOut = 1'b1;
                    else expQ.push_back({refMask(dmac), tag});
                    for (int b = 1; b < len; b++) begin
                        sendBeat(mkBody(), 1'b0, b == len - 1, ok);
                        if (!ok) timedOut = 1'b1;
                    end
                    repeat ($urandom % 3) tick();
                end
            end
            begin
                int cyc = 0;
                while (got < NPKT && cyc < 5000) begin
                    tagout_ready = ($urandom % 3) != 0;
                    if (tagout_valid && tagout_ready) begin
                        logic [13:0] e;
                        e = (expQ.size() > 0) ? expQ.pop_front() : 14'h0;
                        nChecks++; if (tagout_data !== e)
                            $display("[TB] FAIL rand_result[%0d] got %h expected %h", got, tagout_data, e); else nPass++;
                        got++;
                    end
                    tick();
                    cyc++;
                end
                tagout_ready = 1'b0;
            end
        join
        nChecks++; if (got != NPKT || timedOut) $display("[TB] FAIL rand_complete got %0d results timeout=%b expected %0d", got, timedOut, NPKT); else nPass++;
        nChecks++; if (err_count !== 16'd1) $display("[TB] FAIL rand_err got %0d expected 1", err_count); else nPass++;
    endtask

    initial begin
        test_reset();
        test_exact_hit();
        test_miss_bcast();
        test_priority();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
